// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad lock controller:
// key codes, controller states and the ms prescaler helper.
package keypad_pkg;

  localparam logic [3:0] KEY_CLR    = 4'hA;
  localparam logic [3:0] KEY_PROG   = 4'hB;
  localparam logic [3:0] KEY_STAR   = 4'hE;
  localparam logic [3:0] KEY_ENTER  = 4'hF;
  localparam logic [3:0] DIGIT_NONE = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    UNLOCK,
    PROG_NEW,
    PROG_CONFIRM,
    LOCKOUT
  } state_e;

  // Clock cycles per 1 ms tick, never below one.
  function automatic int unsigned ms_ticks(
    input int unsigned freq_hz
  );
    int unsigned n;
    n = freq_hz / 1000;
    return (n > 0) ? n : 1;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms tick: one-cycle tick_o every CLK_FREQ_HZ/1000 cycles.
// Ports: clk_i, rst_ni (async active-low), tick_o.
module ms_tick_gen
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned DIV = ms_ticks(CLK_FREQ_HZ);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_lock_fsm.sv
// Keypad lock controller: PIN entry, retry lockout, timed unlock, reprogramming.
// Ports: clk_i, rst_ni, key_valid_i, key_code_i[3:0] in; status flags and counters out.
module keypad_lock_fsm
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned PIN_LEN     = 5,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned UNLOCK_MS   = 5000,
  parameter int unsigned LOCKOUT_MS  = 30000,
  parameter logic [31:0] DEFAULT_PIN = 32'h0001_2341
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  output logic       unlocked_o,
  output logic       fail_o,
  output logic       locked_out_o,
  output logic       prog_mode_o,
  output logic       prog_err_o,
  output logic [3:0] digit_cnt_o,
  output logic [3:0] last_digit_o,
  output logic [3:0] tries_left_o
);

  localparam int unsigned PW = 4 * PIN_LEN;
  localparam logic [PW-1:0] PIN_RST = DEFAULT_PIN[PW-1:0];
  localparam logic [3:0]  LEN       = 4'(PIN_LEN);
  localparam logic [3:0]  TRIES_MAX = 4'(MAX_TRIES);
  localparam logic [31:0] UNL_LAST  = 32'(UNLOCK_MS - 1);
  localparam logic [31:0] LCK_LAST  = 32'(LOCKOUT_MS - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] pin_q, pin_d;
  logic [PW-1:0] cand_q, cand_d;
  logic [PW-1:0] buf_q, buf_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    last_q, last_d;
  logic [3:0]    tries_q, tries_d;
  logic          fail_q, fail_d;
  logic          perr_q, perr_d;
  logic [31:0]   ms_q, ms_d;

  logic tick;
  logic is_digit, is_clr, is_prog, is_enter;
  logic accepted, entry_full, unl_end, lck_end;

  ms_tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .tick_o(tick)
  );

  assign is_digit   = key_code_i <= 4'd9;
  assign is_clr     = key_code_i == KEY_CLR;
  assign is_prog    = key_code_i == KEY_PROG;
  assign is_enter   = key_code_i == KEY_ENTER;
  assign accepted   = key_valid_i &&
                      !(key_code_i inside {KEY_STAR, 4'hC, 4'hD});
  assign entry_full = (cnt_q == LEN) && !ovf_q;
  assign unl_end    = tick && (ms_q == UNL_LAST);
  assign lck_end    = tick && (ms_q == LCK_LAST);

  always_comb begin
    state_d = state_q;
    pin_d   = pin_q;
    cand_d  = cand_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    tries_d = tries_q;
    fail_d  = fail_q;
    perr_d  = 1'b0;
    ms_d    = ms_q;

    unique case (state_q)
      IDLE, PROG_NEW, PROG_CONFIRM: begin
        if (accepted) fail_d = 1'b0;
        if (key_valid_i) begin
          unique case (1'b1)
            is_digit: begin
              last_d = key_code_i;
              if (cnt_q < LEN) begin
                for (int i = 0; i < PIN_LEN; i++) begin
                  if (cnt_q == 4'(i))
                    buf_d[4*(PIN_LEN-1-i) +: 4] = key_code_i;
                end
                cnt_d = cnt_q + 4'd1;
              end else begin
                ovf_d = 1'b1;
              end
            end
            is_clr: begin
              buf_d  = '0;
              cnt_d  = '0;
              ovf_d  = 1'b0;
              last_d = DIGIT_NONE;
              state_d = IDLE;
            end
            is_enter: begin
              if (state_q == IDLE) begin
                // Buffer is kept so CHECK sees the registered entry.
                state_d = CHECK;
              end else begin
                buf_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                state_d = IDLE;
                if (state_q == PROG_NEW && entry_full) begin
                  cand_d  = buf_q;
                  state_d = PROG_CONFIRM;
                end else if (state_q == PROG_CONFIRM && entry_full &&
                             buf_q == cand_q) begin
                  pin_d = buf_q;
                end else begin
                  perr_d = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
      CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
        if (entry_full && buf_q == pin_q) begin
          tries_d = TRIES_MAX;
          state_d = UNLOCK;
        end else begin
          tries_d = tries_q - 4'd1;
          fail_d  = 1'b1;
          state_d = (tries_q == 4'd1) ? LOCKOUT : IDLE;
        end
      end
      UNLOCK: begin
        if (unl_end) begin
          state_d = IDLE;
        end else if (key_valid_i && is_prog) begin
          state_d = PROG_NEW;
        end else if (key_valid_i && is_clr) begin
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        if (lck_end) begin
          tries_d = TRIES_MAX;
          fail_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Window counter restarts on every state entry.
    if (state_d != state_q)
      ms_d = '0;
    else if (tick && (state_q inside {UNLOCK, LOCKOUT}))
      ms_d = ms_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pin_q   <= PIN_RST;
      cand_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      last_q  <= DIGIT_NONE;
      tries_q <= TRIES_MAX;
      fail_q  <= 1'b0;
      perr_q  <= 1'b0;
      ms_q    <= '0;
    end else begin
      state_q <= state_d;
      pin_q   <= pin_d;
      cand_q  <= cand_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
      tries_q <= tries_d;
      fail_q  <= fail_d;
      perr_q  <= perr_d;
      ms_q    <= ms_d;
    end
  end

  assign unlocked_o   = state_q inside {UNLOCK, PROG_NEW, PROG_CONFIRM};
  assign locked_out_o = state_q == LOCKOUT;
  assign prog_mode_o  = state_q inside {PROG_NEW, PROG_CONFIRM};
  assign fail_o       = fail_q;
  assign prog_err_o   = perr_q;
  assign digit_cnt_o  = cnt_q;
  assign last_digit_o = last_q;
  assign tries_left_o = tries_q;

endmodule

// File: tb/tb_keypad_lock_fsm.sv
// Scoreboard bench for keypad_lock_fsm: expectations are queued per cycle
// and a monitor compares them against the outputs on the falling edge.
module tb_keypad_lock_fsm;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       unlocked, fail, locked_out, prog_mode, prog_err;
  logic [3:0] digit_cnt, last_digit, tries_left;

  keypad_lock_fsm #(
    .CLK_FREQ_HZ(10_000),
    .PIN_LEN    (5),
    .MAX_TRIES  (3),
    .UNLOCK_MS  (5),
    .LOCKOUT_MS (8),
    .DEFAULT_PIN(32'h0001_2341)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .key_valid_i (key_valid),
    .key_code_i  (key_code),
    .unlocked_o  (unlocked),
    .fail_o      (fail),
    .locked_out_o(locked_out),
    .prog_mode_o (prog_mode),
    .prog_err_o  (prog_err),
    .digit_cnt_o (digit_cnt),
    .last_digit_o(last_digit),
    .tries_left_o(tries_left)
  );

  typedef enum int {
    S_UNL, S_FAIL, S_LOCK, S_PROG, S_PERR, S_CNT, S_LAST, S_TRIES
  } sig_e;

  typedef struct {
    string      nm;
    sig_e       s;
    int         cyc;
    logic [3:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [3:0] actual(sig_e s);
    case (s)
      S_UNL:   return {3'b0, unlocked};
      S_FAIL:  return {3'b0, fail};
      S_LOCK:  return {3'b0, locked_out};
      S_PROG:  return {3'b0, prog_mode};
      S_PERR:  return {3'b0, prog_err};
      S_CNT:   return digit_cnt;
      S_LAST:  return last_digit;
      default: return tries_left;
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        checks++;
        if (actual(q[i].s) !== q[i].v) begin
          errors++;
          $display("FAIL %s @cycle %0d: got %0h, expected %0h",
                   q[i].nm, cyc, actual(q[i].s), q[i].v);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_at(string nm, sig_e s, int at, logic [3:0] v);
    exp_t x;
    x.nm  = nm;
    x.s   = s;
    x.cyc = at;
    x.v   = v;
    q.push_back(x);
  endtask

  task automatic expect_reset(string tag);
    expect_at({tag, "_unl"},   S_UNL,   cyc, 4'd0);
    expect_at({tag, "_fail"},  S_FAIL,  cyc, 4'd0);
    expect_at({tag, "_lock"},  S_LOCK,  cyc, 4'd0);
    expect_at({tag, "_prog"},  S_PROG,  cyc, 4'd0);
    expect_at({tag, "_perr"},  S_PERR,  cyc, 4'd0);
    expect_at({tag, "_cnt"},   S_CNT,   cyc, 4'd0);
    expect_at({tag, "_last"},  S_LAST,  cyc, 4'hF);
    expect_at({tag, "_tries"}, S_TRIES, cyc, 4'd3);
  endtask

  // Key sampled at the second rising edge; returns 1 ns after it.
  task automatic press(logic [3:0] k);
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic seq(string s);
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= 8'h30 && c <= 8'h39) press(4'(c - 8'h30));
      else if (c == 8'h23)          press(4'hF);
      else if (c == 8'h41)          press(4'hA);
      else if (c == 8'h42)          press(4'hB);
      else                          press(4'hE);
    end
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    expect_reset("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Correct PIN and unlock window
    seq("12341");
    expect_at("cnt_full", S_CNT,  cyc, 4'd5);
    expect_at("last_1",   S_LAST, cyc, 4'd1);
    seq("#");
    e = cyc + 1;
    expect_at("unl_on",    S_UNL,   e,      4'd1);
    expect_at("unl_tries", S_TRIES, e,      4'd3);
    expect_at("unl_hold",  S_UNL,   e + 39, 4'd1);
    expect_at("unl_off",   S_UNL,   e + 51, 4'd0);
    wait_to(e + 53);

    // Three wrong entries then lockout
    seq("12342#");
    expect_at("w1_fail",  S_FAIL,  cyc + 1, 4'd1);
    expect_at("w1_tries", S_TRIES, cyc + 1, 4'd2);
    seq("12342#");
    expect_at("w2_fail",  S_FAIL,  cyc + 1, 4'd1);
    expect_at("w2_tries", S_TRIES, cyc + 1, 4'd1);
    seq("12342#");
    e = cyc + 1;
    expect_at("lo_on",    S_LOCK,  e, 4'd1);
    expect_at("lo_tries", S_TRIES, e, 4'd0);
    seq("12341#A");
    expect_at("lo_cnt", S_CNT,  cyc, 4'd0);
    expect_at("lo_unl", S_UNL,  cyc, 4'd0);
    expect_at("lo_hold", S_LOCK, e + 69, 4'd1);
    expect_at("lo_off",  S_LOCK, e + 82, 4'd0);
    expect_at("lo_rel",  S_TRIES, e + 82, 4'd3);
    expect_at("lo_fail", S_FAIL, e + 82, 4'd0);
    wait_to(e + 84);

    // Length errors
    seq("123#");
    expect_at("short_fail",  S_FAIL,  cyc + 1, 4'd1);
    expect_at("short_tries", S_TRIES, cyc + 1, 4'd2);
    seq("1");
    expect_at("fail_clr", S_FAIL, cyc, 4'd0);
    seq("23415");
    expect_at("sat_cnt",  S_CNT,  cyc, 4'd5);
    expect_at("sat_last", S_LAST, cyc, 4'd5);
    seq("#");
    expect_at("long_fail",  S_FAIL,  cyc + 1, 4'd1);
    expect_at("long_tries", S_TRIES, cyc + 1, 4'd1);

    // Clear mid-entry
    seq("99");
    expect_at("clr_pre", S_CNT,  cyc, 4'd2);
    expect_at("last_9",  S_LAST, cyc, 4'd9);
    seq("A");
    expect_at("clr_cnt",  S_CNT,  cyc, 4'd0);
    expect_at("clr_last", S_LAST, cyc, 4'hF);
    seq("12341#");
    expect_at("clr_unl",   S_UNL,   cyc + 1, 4'd1);
    expect_at("clr_tries", S_TRIES, cyc + 1, 4'd3);
    seq("A");
    expect_at("relock", S_UNL, cyc, 4'd0);

    // Reprogram with confirm
    seq("12341#B");
    expect_at("pg_mode", S_PROG, cyc, 4'd1);
    expect_at("pg_unl",  S_UNL,  cyc, 4'd1);
    seq("55555#");
    expect_at("pg_conf", S_PROG, cyc, 4'd1);
    expect_at("pg_cnt",  S_CNT,  cyc, 4'd0);
    seq("55555#");
    expect_at("pg_done", S_PROG, cyc, 4'd0);
    expect_at("pg_perr", S_PERR, cyc, 4'd0);
    expect_at("pg_lock", S_UNL,  cyc, 4'd0);
    seq("12341#");
    expect_at("old_pin", S_FAIL, cyc + 1, 4'd1);
    seq("55555#");
    expect_at("new_pin", S_UNL, cyc + 1, 4'd1);
    seq("A");

    // Confirm mismatch
    seq("55555#B66666#66667#");
    expect_at("mm_perr",  S_PERR, cyc,     4'd1);
    expect_at("mm_prog",  S_PROG, cyc,     4'd0);
    expect_at("mm_pulse", S_PERR, cyc + 1, 4'd0);
    seq("55555#");
    expect_at("mm_keep", S_UNL, cyc + 1, 4'd1);
    seq("A");

    // Reset mid-entry reverts everything
    seq("12");
    expect_at("pre_rst", S_CNT, cyc, 4'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    expect_reset("mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seq("55555#");
    expect_at("rv_fail",  S_FAIL,  cyc + 1, 4'd1);
    expect_at("rv_tries", S_TRIES, cyc + 1, 4'd2);
    seq("12341#");
    expect_at("rv_unl", S_UNL, cyc + 1, 4'd1);

    for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d pending, expected 0", q.size());
      errors += q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
